// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the MIPS32 multiply/divide unit (package mdu_defs).
package mdu_defs;

    localparam int unsigned MDU_WIDTH = 32;
    localparam int unsigned MDU_CNT_W = 6;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_FIN  = 2'b10
    } mdu_state_e;

endpackage

// File: rtl/mult_div_unit_if.sv
// Execute-stage <-> multiply/divide unit issue and HI/LO read interface.
interface mult_div_unit_if
    import mdu_defs::*;
#(
    parameter int unsigned WIDTH = MDU_WIDTH
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             mthi;
    logic             mtlo;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, mthi, mtlo,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b, mthi, mtlo,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mult_div_unit_sign_fix.sv
// Operand magnitude extraction and result sign correction for signed MDU ops.
module mdu_sign_fix
    import mdu_defs::*;
#(
    parameter int unsigned WIDTH = MDU_WIDTH
) (
    input  logic               signed_op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [WIDTH-1:0]   mag_a_c,
    output logic [WIDTH-1:0]   mag_b_c,
    output logic               neg_res_c,
    output logic               neg_rem_c,
    input  logic               neg_res,
    input  logic               neg_rem,
    input  logic [2*WIDTH-1:0] prod,
    input  logic [WIDTH-1:0]   quo,
    input  logic [WIDTH-1:0]   rem,
    output logic [2*WIDTH-1:0] prod_fix_c,
    output logic [WIDTH-1:0]   quo_fix_c,
    output logic [WIDTH-1:0]   rem_fix_c
);
    logic sa;
    logic sb;

    // Magnitudes on issue; negate product/quotient on sign mismatch, remainder follows dividend.
    always_comb begin
        sa         = signed_op & a[WIDTH-1];
        sb         = signed_op & b[WIDTH-1];
        mag_a_c    = sa ? -a : a;
        mag_b_c    = sb ? -b : b;
        neg_res_c  = sa ^ sb;
        neg_rem_c  = sa;
        prod_fix_c = neg_res ? -prod : prod;
        quo_fix_c  = neg_res ? -quo : quo;
        rem_fix_c  = neg_rem ? -rem : rem;
    end
endmodule

// File: rtl/mult_div_unit.sv
// Iterative radix-2 multiply/divide unit owning HI/LO.
// Optional macro MDU_EARLY_TERM_EN: multiply finishes as soon as no multiplier bits remain.
module mult_div_unit
    import mdu_defs::*;
#(
    parameter int unsigned WIDTH = MDU_WIDTH,
    parameter int unsigned CNT_W = MDU_CNT_W
) (
    input  logic            clk,
    input  logic            rst,
    mult_div_unit_if.slave  bus
);
    localparam int unsigned W2 = 2 * WIDTH;

    mdu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W2-1:0]    acc_q, acc_d;
    logic [W2-1:0]    mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] a_raw_q, a_raw_d;
    logic             is_div_q, is_div_d;
    logic             neg_res_q, neg_res_d;
    logic             neg_rem_q, neg_rem_d;
    logic             b_zero_q, b_zero_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] mag_a_c, mag_b_c;
    logic             neg_res_c, neg_rem_c;
    logic [W2-1:0]    prod_fix_c;
    logic [WIDTH-1:0] quo_fix_c, rem_fix_c;

    logic [WIDTH:0]   div_sh;
    logic [WIDTH:0]   div_tr;
    logic             q_bit;
    logic [WIDTH-1:0] rem_nx;

    mdu_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
        .signed_op  (~bus.op[0]),
        .a          (bus.a),
        .b          (bus.b),
        .mag_a_c    (mag_a_c),
        .mag_b_c    (mag_b_c),
        .neg_res_c  (neg_res_c),
        .neg_rem_c  (neg_rem_c),
        .neg_res    (neg_res_q),
        .neg_rem    (neg_rem_q),
        .prod       (acc_q),
        .quo        (acc_q[WIDTH-1:0]),
        .rem        (acc_q[W2-1:WIDTH]),
        .prod_fix_c (prod_fix_c),
        .quo_fix_c  (quo_fix_c),
        .rem_fix_c  (rem_fix_c)
    );

    // Restoring divide step: remainder in acc upper half, dividend/quotient in lower half.
    always_comb begin
        div_sh = {acc_q[W2-1:WIDTH], acc_q[WIDTH-1]};
        div_tr = div_sh - {1'b0, mcand_q[WIDTH-1:0]};
        q_bit  = (div_sh >= {1'b0, mcand_q[WIDTH-1:0]});
        rem_nx = q_bit ? div_tr[WIDTH-1:0] : div_sh[WIDTH-1:0];
    end

    // Next-state, datapath and HI/LO update.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        a_raw_d   = a_raw_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        b_zero_d  = b_zero_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    a_raw_d   = bus.a;
                    is_div_d  = bus.op[1];
                    neg_res_d = neg_res_c;
                    neg_rem_d = neg_rem_c;
                    b_zero_d  = (bus.b == '0);
                    mplier_d  = mag_b_c;
                    acc_d     = bus.op[1] ? {WIDTH'(0), mag_a_c} : '0;
                    mcand_d   = {WIDTH'(0), (bus.op[1] ? mag_b_c : mag_a_c)};
                    cnt_d     = CNT_W'(WIDTH);
                    busy_d    = 1'b1;
                    state_d   = S_RUN;
                end else begin
                    if (bus.mthi) hi_d = bus.a;
                    if (bus.mtlo) lo_d = bus.a;
                end
            end
            S_RUN: begin
                if (is_div_q) begin
                    acc_d = {rem_nx, acc_q[WIDTH-2:0], q_bit};
                end else begin
                    if (mplier_q[0]) acc_d = acc_q + mcand_q;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                end
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_FIN;
                end
`ifdef MDU_EARLY_TERM_EN
                else if (!is_div_q && (mplier_q[WIDTH-1:1] == '0)) begin
                    state_d = S_FIN;
                end
`endif
            end
            S_FIN: begin
                if (is_div_q) begin
                    if (b_zero_q) begin
                        lo_d = '1;
                        hi_d = a_raw_q;
                    end else begin
                        lo_d = quo_fix_c;
                        hi_d = rem_fix_c;
                    end
                end else begin
                    {hi_d, lo_d} = prod_fix_c;
                end
                cnt_d   = '0;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            a_raw_q   <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            b_zero_q  <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            a_raw_q   <= a_raw_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            b_zero_q  <= b_zero_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// Directed and randomised checks of mult_div_unit against a behavioural HI/LO model.
module tb_mult_div_unit;
    import mdu_defs::*;

    typedef struct {
        string       tag;
        logic [63:0] res;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;
    exp_t sb[$];
    logic [63:0] last_res;

    mult_div_unit_if #(.WIDTH(32)) bus ();

    mult_div_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb_, q, r, p;
        logic [63:0] res;
        sa = {{32{a[31]}}, a};
        sb_ = {{32{b[31]}}, b};
        res = '0;
        case (op)
            OP_MULT:  begin p = sa * sb_; res = p; end
            OP_MULTU: res = {32'd0, a} * {32'd0, b};
            OP_DIV: begin
                if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
                else begin q = sa / sb_; r = sa % sb_; res = {r[31:0], q[31:0]}; end
            end
            default: begin
                if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
                else res = {a % b, a / b};
            end
        endcase
        return res;
    endfunction

    function automatic int exp_lat(input logic [1:0] op, input logic [31:0] b);
`ifdef MDU_EARLY_TERM_EN
        logic [31:0] mag;
        int idx;
        if (!op[1]) begin
            mag = (op == OP_MULT && b[31]) ? -b : b;
            idx = 0;
            for (int i = 0; i < 32; i++) if (mag[i]) idx = i;
            return idx + 2;
        end
`endif
        return (op[1] || !op[1]) ? 33 : 33;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive a start at the current negedge and record the expected result.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input string tag);
        exp_t e;
        bus.start = 1'b1;
        bus.op = op;
        bus.a = a;
        bus.b = b;
        e.tag = tag;
        e.res = model(op, a, b);
        e.lat = exp_lat(op, b);
        sb.push_back(e);
        @(negedge clk);
        bus.start = 1'b0;
        check({tag, " busy_after_start"}, 64'(bus.busy), 64'd1);
    endtask

    // Wait (bounded) for done, then compare against the scoreboard head.
    task automatic wait_done(input int cyc0);
        exp_t e;
        int cyc, bcnt;
        cyc = cyc0;
        bcnt = cyc0 + 1;
        while (!bus.done && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (bus.busy) bcnt++;
        end
        if (sb.size() == 0) begin
            check("scoreboard_empty", 64'(sb.size()), 64'd1);
        end else begin
            e = sb.pop_front();
            check({e.tag, " done"}, 64'(bus.done), 64'd1);
            check({e.tag, " hilo"}, {bus.hi, bus.lo}, e.res);
            check({e.tag, " latency"}, 64'(cyc), 64'(e.lat));
            check({e.tag, " busy_cycles"}, 64'(bcnt), 64'(e.lat));
            last_res = e.res;
        end
    endtask

    task automatic finish_op();
        wait_done(0);
        @(negedge clk);
        check("done_one_cycle", 64'(bus.done), 64'd0);
    endtask

    initial begin
        int dcnt;
        logic [1:0] rop;
        logic [31:0] ra, rb;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.op = 2'b00;
        bus.a = '0;
        bus.b = '0;
        bus.mthi = 1'b0;
        bus.mtlo = 1'b0;
        last_res = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset hi", 64'(bus.hi), 64'd0);
        check("reset lo", 64'(bus.lo), 64'd0);
        check("reset busy", 64'(bus.busy), 64'd0);
        check("reset done", 64'(bus.done), 64'd0);
        @(negedge clk);

        issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
        finish_op();
        issue(OP_MULT, -32'sd3, 32'd5, "mult_neg3x5");
        finish_op();
        issue(OP_DIV, -32'sd7, 32'd2, "div_neg7/2");
        finish_op();
        issue(OP_DIVU, 32'd7, 32'd2, "divu_7/2");
        finish_op();
        issue(OP_DIVU, 32'd10, 32'd0, "divu_by_zero");
        finish_op();
        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div_overflow");
        finish_op();
        issue(OP_DIV, -32'sd5, 32'd0, "div_neg_by_zero");
        finish_op();

        // start and mthi during a running multiply are ignored
        issue(OP_MULT, 32'd7, 32'hFFFF_FFF9, "mult_ignore_busy");
        repeat (4) @(negedge clk);
        bus.start = 1'b1;
        bus.op = OP_DIVU;
        bus.a = 32'h1234;
        bus.b = 32'd1;
        bus.mthi = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.mthi = 1'b0;
        check("mthi_busy_ignored", 64'(bus.hi), last_res[63:32]);
        wait_done(5);
        @(negedge clk);

        // idle register moves
        bus.mthi = 1'b1;
        bus.a = 32'h1234;
        @(negedge clk);
        bus.mthi = 1'b0;
        check("mthi_idle hi", 64'(bus.hi), 64'h1234);
        check("mthi_idle lo", 64'(bus.lo), 64'(last_res[31:0]));
        bus.mtlo = 1'b1;
        bus.a = 32'h5678;
        @(negedge clk);
        bus.mtlo = 1'b0;
        check("mtlo_idle", {bus.hi, bus.lo}, {32'h1234, 32'h5678});
        bus.mthi = 1'b1;
        bus.mtlo = 1'b1;
        bus.a = 32'hCAFE;
        @(negedge clk);
        bus.mthi = 1'b0;
        bus.mtlo = 1'b0;
        check("mthi_mtlo_both", {bus.hi, bus.lo}, {32'hCAFE, 32'hCAFE});

        // start wins over mthi in the same cycle; HI/LO hold during RUN
        bus.mthi = 1'b1;
        issue(OP_MULTU, 32'd2, 32'd3, "start_beats_mthi");
        bus.mthi = 1'b0;
        check("hold_during_run", {bus.hi, bus.lo}, {32'hCAFE, 32'hCAFE});
        finish_op();

        // back-to-back issue in the done cycle
        issue(OP_MULT, 32'h0001_0000, 32'hFFFF_0000, "b2b_first");
        wait_done(0);
        issue(OP_DIVU, 32'd1000, 32'd7, "b2b_second");
        finish_op();

        // reset in the middle of a divide
        issue(OP_DIV, 32'd12345, 32'd17, "div_reset");
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        void'(sb.pop_front());
        check("midreset state", {30'd0, bus.busy, bus.done, bus.hi}, 64'd0);
        check("midreset lo", 64'(bus.lo), 64'd0);
        dcnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done) dcnt++;
        end
        check("no_done_after_reset", 64'(dcnt), 64'd0);

        // short multipliers (early termination when enabled)
        issue(OP_MULTU, 32'd9, 32'd3, "multu_9x3");
        finish_op();
        issue(OP_MULTU, 32'd9, 32'd0, "multu_9x0");
        finish_op();
        issue(OP_MULT, 32'd9, 32'hFFFF_FFFE, "mult_9xneg2");
        finish_op();

        for (int i = 0; i < 6; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = (i % 2 == 0) ? $urandom : 32'($urandom_range(1, 300));
            issue(rop, ra, rb, "random");
            finish_op();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
